ahblite_busmatrix_inputstage: RTL and testbench

// - Master-facing input stage of the AHB-lite bus matrix: the counterpart to the per-slave output-stage arbiters.
// - Captures each master address phase. Holds it while the target output stage is not granted or is busy.
// - Stalls the master via HREADYOUT and returns the slave data-phase response once the transfer is forwarded.
// - One instance per master port; its hold request feeds the output-stage arbiters.

---
 rtl/ahblite_busmatrix_inputstage.sv | 195 +++++++++++++++++++
 tb/tb_ahblite_busmatrix_inputstage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_busmatrix_inputstage.sv
// ---------------------------------------------------------------------------
// ahblite_busmatrix_inputstage
//
// Master-facing input stage of the AHB-lite bus matrix. Each master address
// phase is either forwarded straight through, when the target output stage
// has granted this master and is ready, or captured into hold registers. A
// captured transfer is replayed from those registers until the output stage
// takes it. The master is stalled through HREADYOUT_in while a transfer is
// held. Once forwarded, the slave data-phase response is passed back unchanged.
//
// Optional feature (compile-time macro AHB_INSTAGE_TIMEOUT_EN):
//   A held transfer that is not forwarded within TIMEOUT cycles is dropped.
//   The master then receives a two-cycle ERROR response.
//
// Parameters:
//   AW        address width
//   TIMEOUT   max pending cycles (2..255), used only with AHB_INSTAGE_TIMEOUT_EN
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   HSEL_in..HPROT_in        master address phase
//   HREADY_in                master-side bus HREADY
//   HREADYOUT_in, HRESP_in   ready / response returned to the master
//   TRANS_HOLD               a held transfer exists (request to the arbiters)
//   HSEL_o..HPROT_o          address phase toward decoder / output stages
//   ACTIVE_ds                target output stage granted this master this cycle
//   HREADY_ds, HRESP_ds      HREADYOUT / HRESP of the selected output stage
// ---------------------------------------------------------------------------
module ahblite_busmatrix_inputstage #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL_in,
    input  logic [AW-1:0] HADDR_in,
    input  logic [1:0]    HTRANS_in,
    input  logic          HWRITE_in,
    input  logic [2:0]    HSIZE_in,
    input  logic [2:0]    HBURST_in,
    input  logic [3:0]    HPROT_in,
    input  logic          HREADY_in,
    output logic          HREADYOUT_in,
    output logic          HRESP_in,
    output logic          TRANS_HOLD,
    output logic          HSEL_o,
    output logic [AW-1:0] HADDR_o,
    output logic [1:0]    HTRANS_o,
    output logic          HWRITE_o,
    output logic [2:0]    HSIZE_o,
    output logic [2:0]    HBURST_o,
    output logic [3:0]    HPROT_o,
    input  logic          ACTIVE_ds,
    input  logic          HREADY_ds,
    input  logic          HRESP_ds
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PEND,
        S_DPHASE
`ifdef AHB_INSTAGE_TIMEOUT_EN
        ,
        S_ERR1,
        S_ERR2
`endif
    } state_t;

    state_t state_q, state_d;

    logic          sel_q;
    logic [AW-1:0] addr_q;
    logic [1:0]    trans_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [2:0]    burst_q;
    logic [3:0]    prot_q;

    logic accept, fwd_ok, pend, load_hold;
    state_t from_idle;

    // Only NONSEQ/SEQ transfers that complete their address phase matter.
    assign accept = HSEL_in & HTRANS_in[1] & HREADY_in;
    assign fwd_ok = ACTIVE_ds & HREADY_ds;
    assign pend   = (state_q == S_PEND);

    // Decision shared by every state in which a new address phase may be taken.
    always_comb begin
        from_idle = S_IDLE;
        if (accept)
            from_idle = fwd_ok ? S_DPHASE : S_PEND;
    end

`ifdef AHB_INSTAGE_TIMEOUT_EN
    logic [7:0] cnt_q;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = from_idle;
            S_PEND: begin
                if (fwd_ok)
                    state_d = S_DPHASE;
`ifdef AHB_INSTAGE_TIMEOUT_EN
                else if (cnt_q == TO_LAST)
                    state_d = S_ERR1;
`endif
            end
            S_DPHASE: if (HREADY_ds) state_d = from_idle;
`ifdef AHB_INSTAGE_TIMEOUT_EN
            S_ERR1:   state_d = S_ERR2;
            S_ERR2:   state_d = from_idle;
`endif
            default:  state_d = S_IDLE;
        endcase
    end

    // Capture only on the actual transition into PEND. The master inputs are
    // ignored while a transfer is already held.
    assign load_hold = (state_d == S_PEND) && (state_q != S_PEND);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            trans_q <= 2'b00;
            write_q <= 1'b0;
            size_q  <= 3'b000;
            burst_q <= 3'b000;
            prot_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            if (load_hold) begin
                sel_q   <= HSEL_in;
                addr_q  <= HADDR_in;
                trans_q <= HTRANS_in;
                write_q <= HWRITE_in;
                size_q  <= HSIZE_in;
                burst_q <= HBURST_in;
                prot_q  <= HPROT_in;
            end
        end
    end

`ifdef AHB_INSTAGE_TIMEOUT_EN
    // The count is zero in the first PEND cycle. This allows exactly TIMEOUT
    // PEND cycles before the transfer is dropped.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            cnt_q <= 8'd0;
        else if (load_hold)
            cnt_q <= 8'd0;
        else if (pend)
            cnt_q <= cnt_q + 8'd1;
    end
`endif

    // Master-side response, decoded from state. DPHASE is a pure pass-through.
    always_comb begin
        HREADYOUT_in = 1'b1;
        HRESP_in     = 1'b0;
        case (state_q)
            S_PEND:   HREADYOUT_in = 1'b0;
            S_DPHASE: begin
                HREADYOUT_in = HREADY_ds;
                HRESP_in     = HRESP_ds;
            end
`ifdef AHB_INSTAGE_TIMEOUT_EN
            S_ERR1: begin
                HREADYOUT_in = 1'b0;
                HRESP_in     = 1'b1;
            end
            S_ERR2:   HRESP_in = 1'b1;
`endif
            default: ;
        endcase
    end

    assign TRANS_HOLD = pend;

    // A held transfer is replayed toward the output stages. Otherwise the
    // live master phase is presented, which keeps a granted transfer at zero
    // added latency.
    assign HSEL_o   = pend ? sel_q   : HSEL_in;
    assign HADDR_o  = pend ? addr_q  : HADDR_in;
    assign HTRANS_o = pend ? trans_q : HTRANS_in;
    assign HWRITE_o = pend ? write_q : HWRITE_in;
    assign HSIZE_o  = pend ? size_q  : HSIZE_in;
    assign HBURST_o = pend ? burst_q : HBURST_in;
    assign HPROT_o  = pend ? prot_q  : HPROT_in;

endmodule

// File: tb/tb_ahblite_busmatrix_inputstage.sv
module tb_ahblite_busmatrix_inputstage;

    localparam int AW = 32;
    localparam int TO = 4;
`ifdef AHB_INSTAGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          HCLK = 1'b0;
    logic          HRESETn;
    logic          HSEL_in;
    logic [AW-1:0] HADDR_in;
    logic [1:0]    HTRANS_in;
    logic          HWRITE_in;
    logic [2:0]    HSIZE_in;
    logic [2:0]    HBURST_in;
    logic [3:0]    HPROT_in;
    logic          HREADY_in;
    logic          HREADYOUT_in, HRESP_in, TRANS_HOLD;
    logic          HSEL_o;
    logic [AW-1:0] HADDR_o;
    logic [1:0]    HTRANS_o;
    logic          HWRITE_o;
    logic [2:0]    HSIZE_o, HBURST_o;
    logic [3:0]    HPROT_o;
    logic          ACTIVE_ds, HREADY_ds, HRESP_ds;

    ahblite_busmatrix_inputstage #(.AW(AW), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .HSEL_in(HSEL_in), .HADDR_in(HADDR_in), .HTRANS_in(HTRANS_in),
        .HWRITE_in(HWRITE_in), .HSIZE_in(HSIZE_in), .HBURST_in(HBURST_in),
        .HPROT_in(HPROT_in), .HREADY_in(HREADY_in),
        .HREADYOUT_in(HREADYOUT_in), .HRESP_in(HRESP_in), .TRANS_HOLD(TRANS_HOLD),
        .HSEL_o(HSEL_o), .HADDR_o(HADDR_o), .HTRANS_o(HTRANS_o), .HWRITE_o(HWRITE_o),
        .HSIZE_o(HSIZE_o), .HBURST_o(HBURST_o), .HPROT_o(HPROT_o),
        .ACTIVE_ds(ACTIVE_ds), .HREADY_ds(HREADY_ds), .HRESP_ds(HRESP_ds)
    );

    always #5 HCLK = ~HCLK;

    localparam logic [1:0] T_IDLE = 2'b00, T_NSEQ = 2'b10, T_SEQ = 2'b11;

    typedef struct packed {
        logic          sel;
        logic [AW-1:0] addr;
        logic [1:0]    trans;
        logic          write;
        logic [2:0]    size;
        logic [2:0]    burst;
        logic [3:0]    prot;
    } req_t;

    // Reference model: at most one held request, a "data phase owed" flag,
    // an error-response phase counter and the time spent waiting.
    req_t held_q[$];
    bit   m_dphase;
    int   m_err;
    int   m_wait;

    int n_chk = 0;
    int n_err = 0;

    // Values observed in the most recent step.
    logic          o_ready, o_resp, o_hold;
    logic [AW-1:0] o_addr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        if (held_q.size() != 0) return 1'b0;
        if (m_err == 1) return 1'b0;
        if (m_err == 2) return 1'b1;
        if (m_dphase) return HREADY_ds;
        return 1'b1;
    endfunction

    function automatic logic m_resp();
        if (held_q.size() != 0) return 1'b0;
        if (m_err != 0) return 1'b1;
        if (m_dphase) return HRESP_ds;
        return 1'b0;
    endfunction

    function automatic req_t live_req();
        return '{HSEL_in, HADDR_in, HTRANS_in, HWRITE_in, HSIZE_in, HBURST_in, HPROT_in};
    endfunction

    task automatic m_clear();
        held_q.delete();
        m_dphase = 0;
        m_err    = 0;
        m_wait   = 0;
    endtask

    task automatic m_update();
        bit   acc, fwd, open;
        req_t r;
        acc = HSEL_in && HTRANS_in[1] && HREADY_in;
        fwd = ACTIVE_ds && HREADY_ds;
        if (held_q.size() != 0) begin
            if (fwd) begin
                r = held_q.pop_front();
                m_dphase = 1;
            end else if (TO_EN && m_wait == TO - 1) begin
                r = held_q.pop_front();
                m_dphase = 0;
                m_err    = 1;
            end else begin
                m_wait++;
            end
        end else if (m_err == 1) begin
            m_err = 2;
        end else begin
            // A new address phase can be taken unless a data phase is still waiting.
            open = (m_err == 2) || !m_dphase || HREADY_ds;
            if (open) begin
                m_err = 0;
                m_dphase = 0;
                if (acc) begin
                    if (fwd) m_dphase = 1;
                    else begin
                        held_q.push_back(live_req());
                        m_wait = 0;
                    end
                end
            end
        end
    endtask

    // One bus cycle: drive at negedge, check just after, advance model at posedge.
    task automatic step(input logic sel, input logic [AW-1:0] addr, input logic [1:0] trans,
                        input logic act, input logic hrdy, input logic hresp);
        req_t er;
        @(negedge HCLK);
        HSEL_in   = sel;
        HADDR_in  = addr;
        HTRANS_in = trans;
        HWRITE_in = 1'($urandom);
        HSIZE_in  = 3'($urandom);
        HBURST_in = 3'($urandom);
        HPROT_in  = 4'($urandom);
        ACTIVE_ds = act;
        HREADY_ds = hrdy;
        HRESP_ds  = hresp;
        HREADY_in = m_ready();
        #1;
        er = (held_q.size() != 0) ? held_q[0] : live_req();
        chk("hreadyout", 64'(HREADYOUT_in), 64'(m_ready()));
        chk("hresp", 64'(HRESP_in), 64'(m_resp()));
        chk("trans_hold", 64'(TRANS_HOLD), 64'(held_q.size() != 0));
        chk("addr_phase", 64'({HSEL_o, HADDR_o, HTRANS_o, HWRITE_o, HSIZE_o, HBURST_o, HPROT_o}), 64'(er));
        o_ready = HREADYOUT_in;
        o_resp  = HRESP_in;
        o_hold  = TRANS_HOLD;
        o_addr  = HADDR_o;
        @(posedge HCLK);
        m_update();
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        m_clear();
        #1;
        chk("rst_hreadyout", 64'(HREADYOUT_in), 64'd1);
        chk("rst_hresp", 64'(HRESP_in), 64'd0);
        chk("rst_hold", 64'(TRANS_HOLD), 64'd0);
        chk("rst_hsel_live", 64'(HSEL_o), 64'(HSEL_in));
        chk("rst_htrans_live", 64'(HTRANS_o), 64'(HTRANS_in));
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
    endtask

    initial begin
        int zeros;
        HRESETn = 1'b0;
        HSEL_in = 0; HADDR_in = '0; HTRANS_in = T_IDLE; HWRITE_in = 0;
        HSIZE_in = 0; HBURST_in = 0; HPROT_in = 0; HREADY_in = 1;
        ACTIVE_ds = 0; HREADY_ds = 1; HRESP_ds = 0;
        m_clear();
        do_reset();

        // Granted NONSEQ: forwarded live, same cycle, no hold.
        step(1, 32'h2000_0000, T_NSEQ, 1, 1, 0);
        chk("g_addr", 64'(o_addr), 64'h2000_0000);
        chk("g_hold", 64'(o_hold), 64'd0);
        step(0, 32'h0, T_IDLE, 1, 0, 0);
        chk("g_dp_wait", 64'(o_ready), 64'd0);
        step(0, 32'h0, T_IDLE, 1, 1, 0);
        chk("g_dp_done", 64'(o_ready), 64'd1);

        // Ungranted NONSEQ: held for 3 cycles while the live address moves.
        step(1, 32'h4000_0010, T_NSEQ, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, $urandom, T_NSEQ, (k == 2), 1, 0);
            chk("p_hold", 64'(o_hold), 64'd1);
            chk("p_ready", 64'(o_ready), 64'd0);
            chk("p_addr", 64'(o_addr), 64'h4000_0010);
        end
        step(0, 32'h0, T_IDLE, 1, 1, 0);
        chk("p_dphase_ready", 64'(o_ready), 64'd1);
        chk("p_dphase_hold", 64'(o_hold), 64'd0);

        // INCR4 granted back-to-back, one wait on beat 2 data.
        zeros = 0;
        step(1, 32'h100, T_NSEQ, 1, 1, 0);
        step(1, 32'h104, T_SEQ, 1, 1, 0); zeros += !o_ready;
        step(1, 32'h108, T_SEQ, 1, 1, 0); zeros += !o_ready;
        step(1, 32'h10C, T_SEQ, 1, 0, 0); zeros += !o_ready;
        chk("b_wait", 64'(o_ready), 64'd0);
        step(1, 32'h10C, T_SEQ, 1, 1, 0); zeros += !o_ready;
        step(0, 32'h0, T_IDLE, 1, 1, 0);  zeros += !o_ready;
        chk("b_zeros", 64'(zeros), 64'd1);

        // Two-cycle slave ERROR passed through.
        step(1, 32'h200, T_NSEQ, 1, 1, 0);
        step(0, 32'h0, T_IDLE, 1, 0, 1);
        chk("e1_resp", 64'(o_resp), 64'd1);
        chk("e1_ready", 64'(o_ready), 64'd0);
        step(0, 32'h0, T_IDLE, 1, 1, 1);
        chk("e2_resp", 64'(o_resp), 64'd1);
        chk("e2_ready", 64'(o_ready), 64'd1);

        // Reset while PEND.
        step(1, 32'h300, T_NSEQ, 0, 1, 0);
        step(1, 32'h304, T_NSEQ, 0, 1, 0);
        chk("r_pend", 64'(o_hold), 64'd1);
        do_reset();
        step(0, 32'h0, T_IDLE, 0, 1, 0);
        chk("r_idle_ready", 64'(o_ready), 64'd1);
        chk("r_idle_hold", 64'(o_hold), 64'd0);

`ifdef AHB_INSTAGE_TIMEOUT_EN
        // Never granted: TO pending cycles, then ERR1, ERR2.
        step(1, 32'h500, T_NSEQ, 0, 1, 0);
        for (int k = 0; k < TO; k++) begin
            step(0, 32'h0, T_IDLE, 0, 1, 0);
            chk("t_pend", 64'(o_hold), 64'd1);
        end
        step(0, 32'h0, T_IDLE, 0, 1, 0);
        chk("t_err1", 64'({o_hold, o_ready, o_resp}), 64'b001);
        step(0, 32'h0, T_IDLE, 0, 1, 0);
        chk("t_err2", 64'({o_hold, o_ready, o_resp}), 64'b011);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] tr;
            tr = 2'($urandom);
            step(($urandom_range(0, 3) != 0), $urandom, tr,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0));
            if (i % 700 == 699) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
